vid_frame_seq: RTL and testbench
================================

VID_FRAME_SEQ -- requirements
Module: vid_frame_seq

Interface
REQ-001 SHALL have parameter H_ACT, default 64: active pixels per line.
REQ-002 SHALL have parameter H_BLANK, default 16: blank cycles per line, minimum 1.
REQ-003 SHALL have parameter V_ACT, default 48: active lines per frame.
REQ-004 SHALL have parameter V_BLANK, default 4: blank lines before each frame's active lines, minimum 1.
REQ-005 SHALL have parameter DW, default 12: pixel data width.
REQ-006 SHALL have port clk, input, width 1: clock, rising edge.
REQ-007 SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, width 1: pulse that launches a frame sequence.
REQ-009 SHALL have port num_frames, input, width 8: frames to emit; sampled only when start is accepted.
REQ-010 SHALL have port pix_req, output, width 1: pixel fetch strobe to the source.
REQ-011 SHALL have port pix_vld, input, width 1: source data valid, same cycle as pix_req.
REQ-012 SHALL have port pix_data, input, width DW: source pixel.
REQ-013 SHALL have port outV, output, width 1: frame-active sync to the downstream sink.
REQ-014 SHALL have port outH, output, width 1: pixel-valid to the downstream sink.
REQ-015 SHALL have port outDATA, output, width DW: pixel to the downstream sink.
REQ-016 SHALL have outputs busy (1), done (1), frame_idx (8) and underflow (1): status.

Function
REQ-017 SHALL implement the states IDLE, VBLANK, ACTIVE and DONE.
REQ-018 IDLE: start=1 SHALL latch num_frames, clear frame_idx and underflow, and go to VBLANK when num_frames>0, or to DONE when num_frames=0.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 Line length SHALL be H_ACT+H_BLANK cycles, counted by an h counter that wraps to 0.
REQ-021 VBLANK SHALL last V_BLANK lines and then go to ACTIVE.
REQ-022 ACTIVE SHALL last V_ACT lines.
REQ-023 At the end of ACTIVE, frame_idx SHALL increment, and the block SHALL go to VBLANK if frame_idx+1<N, else to DONE.
REQ-024 pix_req SHALL be 1 exactly when state=ACTIVE and h<H_ACT.
REQ-025 outV, outH and outDATA SHALL be registered, with one-cycle latency from the controlling state and pix_req.
REQ-026 outV SHALL equal the delayed (state==ACTIVE), giving V_ACT*(H_ACT+H_BLANK) consecutive cycles per frame.
REQ-027 outH SHALL equal the delayed pix_req, and its first rise SHALL coincide with the outV rise.
REQ-028 outDATA SHALL be pix_data when pix_req&pix_vld, 0 when pix_req&~pix_vld, and hold its previous value otherwise.
REQ-029 pix_req&~pix_vld SHALL set underflow; underflow is sticky until the next accepted start or rst; outH is still asserted, so timing never stalls.
REQ-030 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-031 busy SHALL be 1 in VBLANK and ACTIVE.
REQ-032 frame_idx SHALL be 8-bit unsigned and never wraps, because it stops at N.
REQ-033 done SHALL be asserted N*(V_BLANK+V_ACT)*(H_ACT+H_BLANK)+1 cycles after the accepted start edge.

Reset
REQ-034 rst SHALL put the block in IDLE and clear the h and v counters, frame_idx, outV, outH, outDATA, busy, done and underflow to 0.
REQ-035 rst mid-frame SHALL abort immediately, with outV and outH low from the next cycle and no done pulse.

Configuration
REQ-036 VFS_TESTPAT_EN defined SHALL add a port test_pat (input, 1), sampled at start.
REQ-037 With VFS_TESTPAT_EN defined and test_pat=1, the block SHALL hold pix_req at 0, set outDATA to {h[DW/2-1:0], v[DW/2-1:0]} of the active line, and never set underflow.
REQ-038 With VFS_TESTPAT_EN undefined, the test_pat port SHALL be absent and only the source path exists.

Structure
REQ-039 Package vfs_pkg SHALL hold the state enum, the default timing constants and the DW default.
REQ-040 Sub-module vfs_timing_cnt SHALL contain the h and v counters, with line-end and frame-end strobes.

Verification (H_ACT=4, H_BLANK=2, V_ACT=3, V_BLANK=1, DW=12)
REQ-041 Scenario: start with num_frames=1 and pix_vld=1 -> outH high for 12 cycles in 3 runs of 4; outV high for 18 cycles; done pulses 25 cycles after start.
REQ-042 Scenario: start with num_frames=2 -> frame_idx goes 0,1,2; two outV pulses 6 cycles apart; done at cycle 49.
REQ-043 Scenario: start with num_frames=0 -> done next cycle; outV never rises; busy stays 0.
REQ-044 Scenario: pix_vld=0 on the 2nd pixel of line 1 -> outDATA=0x000 on that outH cycle; underflow=1 until the next start.
REQ-045 Scenario: rst asserted mid line 2, then a second start while busy -> outV and outH are 0 the cycle after rst; the start while busy leaves frame_idx unchanged.
REQ-046 Scenario: with VFS_TESTPAT_EN and test_pat=1 -> pix_req stays 0; the first active pixel outDATA=0x000 and the last pixel of line 3 is 0x0C2.

Source files
------------

// File: rtl/vfs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vfs_pkg : shared state encoding, default timing and width helper           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vfs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } vfs_state_t;

    localparam int c_h_act_def   = 64;
    localparam int c_h_blank_def = 16;
    localparam int c_v_act_def   = 48;
    localparam int c_v_blank_def = 4;
    localparam int c_dw_def      = 12;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_frame_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vid_frame_seq_if : pixel source fetch and downstream sink signals          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vid_frame_seq_if
    import vfs_pkg::*;
#(
    parameter int DW = c_dw_def
);
    logic          pix_req;
    logic          pix_vld;
    logic [DW-1:0] pix_data;
    logic          outV;
    logic          outH;
    logic [DW-1:0] outDATA;

    modport master (output pix_req, outV, outH, outDATA, input pix_vld, pix_data);
    modport slave  (input pix_req, outV, outH, outDATA, output pix_vld, pix_data);
endinterface
`default_nettype wire

// File: rtl/vfs_timing_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vfs_timing_cnt : h/v raster counters with line-end and frame-end strobes   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vfs_timing_cnt
    import vfs_pkg::*;
#(
    parameter int H_ACT   = c_h_act_def,
    parameter int H_BLANK = c_h_blank_def,
    parameter int V_ACT   = c_v_act_def,
    parameter int V_BLANK = c_v_blank_def,
    parameter int HW      = cnt_w(H_ACT + H_BLANK),
    parameter int VW      = cnt_w(V_BLANK + V_ACT)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          line_end,
    output logic          frame_end
);
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;

    // v counts every line of the frame, blank lines first.
    assign line_end  = (r_h == HW'(H_ACT + H_BLANK - 1));
    assign frame_end = line_end && (r_v == VW'(V_BLANK + V_ACT - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_h <= '0;
            r_v <= '0;
        end else if (line_end) begin
            r_h <= '0;
            r_v <= frame_end ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    assign h = r_h;
    assign v = r_v;
endmodule
`default_nettype wire

// File: rtl/vid_frame_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vid_frame_seq : emits N frames of blank/active raster timing, fetching     |
// | pixels from a source. Optional test pattern: define VFS_TESTPAT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vid_frame_seq
    import vfs_pkg::*;
#(
    parameter int H_ACT   = c_h_act_def,
    parameter int H_BLANK = c_h_blank_def,
    parameter int V_ACT   = c_v_act_def,
    parameter int V_BLANK = c_v_blank_def,
    parameter int DW      = c_dw_def
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             num_frames,
`ifdef VFS_TESTPAT_EN
    input  logic                   test_pat,
`endif
    vid_frame_seq_if.master        vid,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             frame_idx,
    output logic                   underflow
);
    localparam int HW = cnt_w(H_ACT + H_BLANK);
    localparam int VW = cnt_w(V_BLANK + V_ACT);

    vfs_state_t    r_state, w_state_nxt;
    logic [7:0]    r_num, r_frame_idx;
    logic          r_uf, r_done, r_outv, r_outh;
    logic [DW-1:0] r_outd;
    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_line_end, w_frame_end, w_run, w_pix_slot, w_last_frame, w_accept;
    logic          w_tp_on;
    logic [DW-1:0] w_tp_pix;

    assign w_run        = (r_state == ST_VBLANK) || (r_state == ST_ACTIVE);
    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_last_frame = ({1'b0, r_frame_idx} + 9'd1) >= {1'b0, r_num};

    vfs_timing_cnt #(
        .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT), .V_BLANK(V_BLANK), .HW(HW), .VW(VW)
    ) u_cnt (
        .clk(clk), .rst(rst), .en(w_run),
        .h(w_h), .v(w_v), .line_end(w_line_end), .frame_end(w_frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pix_slot  = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = (num_frames == 8'd0) ? ST_DONE : ST_VBLANK;
            ST_VBLANK: if (w_line_end && (w_v == VW'(V_BLANK - 1))) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                w_pix_slot = (w_h < HW'(H_ACT));
                if (w_frame_end) w_state_nxt = w_last_frame ? ST_DONE : ST_VBLANK;
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef VFS_TESTPAT_EN
    logic          r_tp;
    logic [VW-1:0] w_act_line;

    always_ff @(posedge clk) begin
        if (rst)           r_tp <= 1'b0;
        else if (w_accept) r_tp <= test_pat;
    end

    // Pattern carries the pixel column and the active-line index.
    assign w_act_line = w_v - VW'(V_BLANK);
    assign w_tp_pix   = DW'({(DW/2)'(w_h), (DW/2)'(w_act_line)});
    assign w_tp_on    = r_tp;
`else
    assign w_tp_pix   = '0;
    assign w_tp_on    = 1'b0;
`endif

    assign vid.pix_req = w_pix_slot && !w_tp_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outv <= 1'b0;
            r_outh <= 1'b0;
            r_outd <= '0;
        end else begin
            r_outv <= (r_state == ST_ACTIVE);
            r_outh <= w_pix_slot;
            if (w_pix_slot)
                r_outd <= w_tp_on ? w_tp_pix : (vid.pix_vld ? vid.pix_data : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num       <= 8'd0;
            r_frame_idx <= 8'd0;
            r_uf        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_num       <= num_frames;
                r_frame_idx <= 8'd0;
                r_uf        <= 1'b0;
            end else begin
                if ((r_state == ST_ACTIVE) && w_frame_end) r_frame_idx <= r_frame_idx + 8'd1;
                // A missing pixel is flagged but the raster keeps running.
                if (vid.pix_req && !vid.pix_vld) r_uf <= 1'b1;
            end
        end
    end

    assign vid.outV    = r_outv;
    assign vid.outH    = r_outh;
    assign vid.outDATA = r_outd;
    assign busy        = w_run;
    assign done        = r_done;
    assign frame_idx   = r_frame_idx;
    assign underflow   = r_uf;
endmodule
`default_nettype wire

// File: tb/tb_vid_frame_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vid_frame_seq : randomized self-checking bench with raster model        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vid_frame_seq;
    localparam int H_ACT = 4, H_BLANK = 2, V_ACT = 3, V_BLANK = 1, DW = 12;
    localparam int L = H_ACT + H_BLANK;
    localparam int F = (V_BLANK + V_ACT) * L;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_frames = 8'd0;
`ifdef VFS_TESTPAT_EN
    logic       test_pat = 1'b0;
`endif
    logic       busy, done, underflow;
    logic [7:0] frame_idx;

    vid_frame_seq_if #(.DW(DW)) vif ();

    vid_frame_seq #(
        .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT), .V_BLANK(V_BLANK), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
`ifdef VFS_TESTPAT_EN
        .test_pat(test_pat),
`endif
        .vid(vif), .busy(busy), .done(done), .frame_idx(frame_idx), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] m_dout = '0;
    logic [DW-1:0] outd_log [0:255];
    logic          outv_log [0:255];
    logic          outh_log [0:255];

    // Raster position s counts cycles from the first blank cycle of frame 0.
    function automatic bit m_act(input int s);
        return ((s % F) / L) >= V_BLANK;
    endfunction

    function automatic bit m_pix(input int s);
        return m_act(s) && ((s % L) < H_ACT);
    endfunction

    task automatic run_seq(input int n, input int bad_s, input bit rnd, input int glitch_s,
                           input int rst_s, input bit tp,
                           output int n_h, output int n_v, output int done_k);
        int total;
        bit aborted, m_uf, in_run, slot, vld, exp_v, exp_h, exp_done;
        int exp_f;
        logic [DW-1:0] dat;
        total = n * F;
        n_h = 0; n_v = 0; done_k = -1; aborted = 0; m_uf = 0;
        outv_log[0] = 1'b0; outh_log[0] = 1'b0;
        @(negedge clk);
        start = 1'b1; num_frames = 8'(n);
`ifdef VFS_TESTPAT_EN
        test_pat = tp;
`endif
        @(posedge clk); #1;
        start = 1'b0; num_frames = 8'($urandom);
        for (int k = 1; k <= total + 3; k++) begin
            int s;
            s = k - 1;
            in_run = !aborted && (s < total);
            slot   = in_run && m_pix(s);
            vld    = rnd ? ($urandom_range(7, 0) != 0) : (s != bad_s);
            if (tp) vld = 1'b0;
            dat = DW'($urandom);
            vif.pix_vld = vld; vif.pix_data = dat;
            if (s == glitch_s) begin start = 1'b1; num_frames = 8'd0; end
            rst = (s == rst_s);
            @(negedge clk);
            n_cmp++; if (vif.pix_req !== (slot && !tp)) begin n_err++;
                $display("FAIL pix_req s=%0d got %b exp %b", s, vif.pix_req, slot && !tp); end
            n_cmp++; if (busy !== in_run) begin n_err++;
                $display("FAIL busy s=%0d got %b exp %b", s, busy, in_run); end
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0;
            if (s == rst_s) begin aborted = 1; m_dout = '0; m_uf = 0; end
            else if (slot) begin
                if (tp) m_dout = DW'(((s % L) << (DW / 2)) | ((s % F) / L - V_BLANK));
                else if (vld) m_dout = dat;
                else begin m_dout = '0; m_uf = 1; end
            end
            exp_v    = in_run && !aborted && m_act(s);
            exp_h    = exp_v && ((s % L) < H_ACT);
            exp_done = !aborted && (k == total + 1);
            exp_f    = aborted ? 0 : ((k / F < n) ? k / F : n);
            n_cmp++; if (vif.outV !== exp_v) begin n_err++;
                $display("FAIL outV k=%0d got %b exp %b", k, vif.outV, exp_v); end
            n_cmp++; if (vif.outH !== exp_h) begin n_err++;
                $display("FAIL outH k=%0d got %b exp %b", k, vif.outH, exp_h); end
            n_cmp++; if (vif.outDATA !== m_dout) begin n_err++;
                $display("FAIL outDATA k=%0d got %h exp %h", k, vif.outDATA, m_dout); end
            n_cmp++; if (done !== exp_done) begin n_err++;
                $display("FAIL done k=%0d got %b exp %b", k, done, exp_done); end
            n_cmp++; if (frame_idx !== 8'(exp_f)) begin n_err++;
                $display("FAIL frame_idx k=%0d got %0d exp %0d", k, frame_idx, exp_f); end
            n_cmp++; if (underflow !== m_uf) begin n_err++;
                $display("FAIL underflow k=%0d got %b exp %b", k, underflow, m_uf); end
            outd_log[k] = vif.outDATA; outv_log[k] = vif.outV; outh_log[k] = vif.outH;
            if (vif.outH === 1'b1) n_h++;
            if (vif.outV === 1'b1) n_v++;
            if (done === 1'b1 && done_k < 0) done_k = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vif.pix_vld = 1'b0; vif.pix_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_dout = '0;
        @(negedge clk);
        n_cmp++; if ({vif.outV, vif.outH, busy, done, underflow, vif.pix_req} !== 6'b0) begin n_err++;
            $display("FAIL reset_flags got %b exp 000000",
                     {vif.outV, vif.outH, busy, done, underflow, vif.pix_req}); end
        n_cmp++; if (vif.outDATA !== '0) begin n_err++;
            $display("FAIL reset_outDATA got %h exp 000", vif.outDATA); end
        n_cmp++; if (frame_idx !== 8'd0) begin n_err++;
            $display("FAIL reset_frame_idx got %0d exp 0", frame_idx); end
    endtask

    task automatic test_single_frame();
        int nh, nv, dk, runs;
        run_seq(1, -1, 0, -1, -1, 0, nh, nv, dk);
        runs = 0;
        for (int k = 1; k <= F + 3; k++) if (outh_log[k] && !outh_log[k-1]) runs++;
        n_cmp++; if (nh != 12) begin n_err++; $display("FAIL single_outH_cycles got %0d exp 12", nh); end
        n_cmp++; if (runs != 3) begin n_err++; $display("FAIL single_outH_runs got %0d exp 3", runs); end
        n_cmp++; if (nv != 18) begin n_err++; $display("FAIL single_outV_cycles got %0d exp 18", nv); end
        n_cmp++; if (dk != 25) begin n_err++; $display("FAIL single_done_at got %0d exp 25", dk); end
    endtask

    task automatic test_multi_frame();
        int nh, nv, dk, rises, rise2, fall;
        run_seq(2, -1, 0, -1, -1, 0, nh, nv, dk);
        rises = 0; rise2 = -1; fall = -1;
        for (int k = 1; k <= 2 * F + 3; k++) begin
            if (outv_log[k] && !outv_log[k-1]) begin rises++; if (rises == 2) rise2 = k; end
            if (!outv_log[k] && outv_log[k-1] && fall < 0) fall = k;
        end
        n_cmp++; if (rises != 2) begin n_err++; $display("FAIL multi_outV_pulses got %0d exp 2", rises); end
        n_cmp++; if (rise2 - fall != 6) begin n_err++; $display("FAIL multi_outV_gap got %0d exp 6", rise2 - fall); end
        n_cmp++; if (dk != 49) begin n_err++; $display("FAIL multi_done_at got %0d exp 49", dk); end
        n_cmp++; if (frame_idx !== 8'd2) begin n_err++; $display("FAIL multi_frame_idx got %0d exp 2", frame_idx); end
    endtask

    task automatic test_zero_frames();
        int nh, nv, dk;
        run_seq(0, -1, 0, -1, -1, 0, nh, nv, dk);
        n_cmp++; if (dk != 1) begin n_err++; $display("FAIL zero_done_at got %0d exp 1", dk); end
        n_cmp++; if (nv != 0) begin n_err++; $display("FAIL zero_outV_cycles got %0d exp 0", nv); end
    endtask

    task automatic test_underflow();
        int nh, nv, dk;
        run_seq(1, V_BLANK * L + 1, 0, -1, -1, 0, nh, nv, dk);
        n_cmp++; if (outd_log[V_BLANK * L + 2] !== 12'h000) begin n_err++;
            $display("FAIL uf_pixel_data got %h exp 000", outd_log[V_BLANK * L + 2]); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got %b exp 1", underflow); end
        n_cmp++; if (nh != 12) begin n_err++; $display("FAIL uf_outH_cycles got %0d exp 12", nh); end
    endtask

    task automatic test_abort_restart();
        int nh, nv, dk, rs;
        rs = (V_BLANK + 1) * L + 2;
        run_seq(3, -1, 0, -1, rs, 0, nh, nv, dk);
        n_cmp++; if (outv_log[rs] !== 1'b1 || outh_log[rs] !== 1'b1) begin n_err++;
            $display("FAIL abort_pre got %b%b exp 11", outv_log[rs], outh_log[rs]); end
        n_cmp++; if (outv_log[rs + 1] !== 1'b0 || outh_log[rs + 1] !== 1'b0) begin n_err++;
            $display("FAIL abort_post got %b%b exp 00", outv_log[rs + 1], outh_log[rs + 1]); end
        n_cmp++; if (dk != -1) begin n_err++; $display("FAIL abort_no_done got %0d exp -1", dk); end
        run_seq(1, -1, 0, 10, -1, 0, nh, nv, dk);
        n_cmp++; if (dk != 25) begin n_err++; $display("FAIL restart_done_at got %0d exp 25", dk); end
        n_cmp++; if (frame_idx !== 8'd1) begin n_err++; $display("FAIL restart_frame_idx got %0d exp 1", frame_idx); end
    endtask

    task automatic test_random();
        int nh, nv, dk, n;
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(3, 1);
            run_seq(n, -1, 1, -1, -1, 0, nh, nv, dk);
            n_cmp++; if (dk != n * F + 1) begin n_err++;
                $display("FAIL rand_done_at n=%0d got %0d exp %0d", n, dk, n * F + 1); end
            n_cmp++; if (nh != n * V_ACT * H_ACT) begin n_err++;
                $display("FAIL rand_outH_cycles n=%0d got %0d exp %0d", n, nh, n * V_ACT * H_ACT); end
        end
    endtask

`ifdef VFS_TESTPAT_EN
    task automatic test_testpat();
        int nh, nv, dk;
        run_seq(1, -1, 0, -1, -1, 1, nh, nv, dk);
        n_cmp++; if (outd_log[V_BLANK * L + 1] !== 12'h000) begin n_err++;
            $display("FAIL tp_first got %h exp 000", outd_log[V_BLANK * L + 1]); end
        n_cmp++; if (outd_log[(V_BLANK + 2) * L + H_ACT] !== 12'h0C2) begin n_err++;
            $display("FAIL tp_last got %h exp 0c2", outd_log[(V_BLANK + 2) * L + H_ACT]); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL tp_underflow got %b exp 0", underflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_zero_frames();
        test_underflow();
        test_abort_restart();
        test_random();
`ifdef VFS_TESTPAT_EN
        test_testpat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
